// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational fp_adder between two requesters.
// Optional grant statistics counters are built when FP_ADD_ARB_STATS_EN is defined.

`timescale 1ns/1ps

module fp_adder (
    input  logic [12:0] i_a,
    input  logic [12:0] i_b,
    output logic [12:0] o_sum
);
    logic [12:0] w_big;
    logic [12:0] w_small;
    logic [3:0]  w_shift;
    logic [7:0]  w_small_al;
    logic [8:0]  w_add;
    logic [7:0]  w_diff;
    logic [3:0]  w_lz;
    logic [3:0]  w_norm;

    always_comb begin
        w_big      = i_a;
        w_small    = i_b;
        if ((i_b[11:8] > i_a[11:8]) || ((i_b[11:8] == i_a[11:8]) && (i_b[7:0] > i_a[7:0]))) begin
            w_big   = i_b;
            w_small = i_a;
        end
        w_shift    = w_big[11:8] - w_small[11:8];
        w_small_al = w_small[7:0] >> w_shift;
        w_add      = {1'b0, w_big[7:0]} + {1'b0, w_small_al};
        w_diff     = w_big[7:0] - w_small_al;

        // Leading-zero count of the difference; highest set bit wins.
        w_lz = 4'd8;
        for (int i = 0; i < 8; i++) begin
            if (w_diff[i]) w_lz = 4'(7 - i);
        end
        w_norm = (w_lz > w_big[11:8]) ? w_big[11:8] : w_lz;

        o_sum = 13'd0;
        if (w_big[12] == w_small[12]) begin
            if (w_add[8]) o_sum = {w_big[12], w_big[11:8] + 4'd1, w_add[8:1]};
            else          o_sum = {w_big[12], w_big[11:8], w_add[7:0]};
        end else if (w_diff != 8'd0) begin
            o_sum = {w_big[12], w_big[11:8] - w_norm, w_diff << w_norm};
        end
    end
endmodule

// state | meaning
// IDLE  | waiting for a request, arbitration active
// EXEC  | operand registers drive fp_adder
// RESP  | response held until resp_ready
module fp_add_arbiter #(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [12:0] req0_a,
    input  logic [12:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [12:0] req1_a,
    input  logic [12:0] req1_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [12:0] resp_data,
    output logic        busy,
    output logic [7:0]  grant_cnt0,
    output logic [7:0]  grant_cnt1
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_prio;
    logic [12:0] r_op_a;
    logic [12:0] r_op_b;
    logic        r_id_q;
    logic        r_resp_valid;
    logic        r_resp_id;
    logic [12:0] r_resp_data;
    logic        w_grant0;
    logic        w_grant1;
    logic [12:0] w_sum;

    fp_adder u_adder (
        .i_a   (r_op_a),
        .i_b   (r_op_b),
        .o_sum (w_sum)
    );

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE && reset_n) begin
            w_grant0 = req0_valid && (!req1_valid || !r_prio);
            w_grant1 = req1_valid && (!req0_valid ||  r_prio);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant0 || w_grant1) w_state_nxt = EXEC;
            EXEC:    w_state_nxt = RESP;
            RESP:    if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio       <= PRIO_INIT;
            r_op_a       <= 13'd0;
            r_op_b       <= 13'd0;
            r_id_q       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= 13'd0;
        end else begin
            if (w_grant0) begin
                r_op_a <= req0_a;
                r_op_b <= req0_b;
                r_id_q <= 1'b0;
                r_prio <= 1'b1;
            end else if (w_grant1) begin
                r_op_a <= req1_a;
                r_op_b <= req1_b;
                r_id_q <= 1'b1;
                r_prio <= 1'b0;
            end
            if (r_state == EXEC) begin
                r_resp_data  <= w_sum;
                r_resp_id    <= r_id_q;
                r_resp_valid <= 1'b1;
            end else if (r_state == RESP && resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

`ifdef FP_ADD_ARB_STATS_EN
    logic [7:0] r_cnt0;
    logic [7:0] r_cnt1;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else begin
            if (w_grant0 && r_cnt0 != 8'hFF) r_cnt0 <= r_cnt0 + 8'd1;
            if (w_grant1 && r_cnt1 != 8'hFF) r_cnt1 <= r_cnt1 + 8'd1;
        end
    end

    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;
`else
    assign grant_cnt0 = 8'd0;
    assign grant_cnt1 = 8'd0;
`endif

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench for fp_add_arbiter: accepts push expected responses, a monitor pops on handshake.

`timescale 1ns/1ps

module tb_fp_add_arbiter;
    localparam logic [12:0] A0 = 13'b0_0100_10000100;
    localparam logic [12:0] B0 = 13'b0_0011_10001000;
    localparam logic [12:0] S0 = 13'b0_0100_11001000;
    localparam logic [12:0] A1 = 13'b0_0100_10000000;
    localparam logic [12:0] S1 = 13'b0_0101_10000000;
`ifdef FP_ADD_ARB_STATS_EN
    localparam int CNT_CONT = 2;
    localparam int CNT_SAT  = 255;
`else
    localparam int CNT_CONT = 0;
    localparam int CNT_SAT  = 0;
`endif

    typedef struct {
        logic        id;
        logic [12:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [12:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id, busy;
    logic [12:0] resp_data;
    logic [7:0]  grant_cnt0, grant_cnt1;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    fp_add_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && resp_valid && resp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("resp_id", 32'(resp_id), 32'(mon_e.id));
                chk("resp_data", 32'(resp_data), 32'(mon_e.data));
            end
        end
    end

    task automatic wait_accept(input bit id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) ok = 1'b1;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int k;
        int lat;
        logic seen;

        reset_n    = 1'b0;
        resp_ready = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = A0; req0_b = B0;
        req1_a = A1; req1_b = A1;

        // Reset with both requesters asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        chk("rst_ready1", 32'(req1_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
        chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;

        // Single operation with back-pressure.
        @(posedge clk); #1 req0_valid = 1'b1;
        wait_accept(1'b0, ok);
        q.push_back('{1'b0, S0});
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_exec_valid", 32'(resp_valid), 32'd0);
        chk("t1_exec_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t1_hold_valid", 32'(resp_valid), 32'd1);
            chk("t1_hold_id", 32'(resp_id), 32'd0);
            chk("t1_hold_data", 32'(resp_data), 32'(S0));
        end
        @(posedge clk); #1 resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_cleared", 32'(resp_valid), 32'd0);
        chk("t1_data_kept", 32'(resp_data), 32'(S0));
        chk("t1_idle", 32'(busy), 32'd0);

        // Normalisation carry from requester 1.
        @(posedge clk); #1 req1_valid = 1'b1;
        wait_accept(1'b1, ok);
        q.push_back('{1'b1, S1});
        @(posedge clk); #1 req1_valid = 1'b0;
        drain();

        // Contention from reset priority: grants must alternate 0,1,0,1.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1;
        k = 0;
        for (int c = 0; c < 60 && k < 4; c++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) begin
                chk("one_hot", 32'(req0_ready & req1_ready), 32'd0);
                chk("grant_order", 32'(req1_ready), 32'(k % 2));
                q.push_back('{1'(k % 2), (k % 2 == 1) ? S1 : S0});
                k++;
            end
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        chk("contention_grants", 32'(k), 32'd4);
        drain();
        chk("cont_cnt0", 32'(grant_cnt0), 32'(CNT_CONT));
        chk("cont_cnt1", 32'(grant_cnt1), 32'(CNT_CONT));

        // Reset during EXEC discards the operation.
        @(posedge clk); #1 req0_valid = 1'b1;
        wait_accept(1'b0, ok);
        @(posedge clk); #1 req0_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        chk("midrst_no_resp", 32'(seen), 32'd0);
        @(posedge clk); #1 req1_valid = 1'b1;
        wait_accept(1'b1, ok);
        q.push_back('{1'b1, S1});
        lat = 0;
        @(posedge clk); #1 req1_valid = 1'b0;
        for (int i = 1; i <= 10 && lat == 0; i++) begin
            @(negedge clk);
            if (resp_valid) lat = i;
        end
        chk("midrst_latency", 32'(lat), 32'd2);
        drain();

        // 300 back-to-back requester-0 operations.
        do_reset();
        req0_valid = 1'b1;
        k = 0;
        for (int c = 0; c < 2000 && k < 300; c++) begin
            @(negedge clk);
            if (req0_ready) begin
                q.push_back('{1'b0, S0});
                k++;
            end
        end
        @(posedge clk); #1 req0_valid = 1'b0;
        chk("sat_ops", 32'(k), 32'd300);
        drain();
        chk("sat_cnt0", 32'(grant_cnt0), 32'(CNT_SAT));
        chk("sat_cnt1", 32'(grant_cnt1), 32'd0);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
